lighthouse_sensor_arbiter: RTL

Collects decoded sweep samples from up to 16 `lighthouse_sensor` decoder instances and shares the single Avalon readout path between them. Each decoder's `valid` pulse latches its `combined_data` into a per-sensor holding slot. A round-robin scheduler moves pending slots into a sample FIFO tagged with the sensor index. The HPS drains the FIFO through an Avalon-MM slave, replacing the per-sensor polling registers in the top-level DarkRoom wrapper.

---
 rtl/lighthouse_arbiter_pkg.sv | 48 ++++
 rtl/lighthouse_sample_fifo.sv | 65 ++++++
 rtl/lighthouse_sensor_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lighthouse_arbiter_pkg.sv
// Shared constants and types for the lighthouse sensor arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lighthouse_arbiter_pkg;

  // Avalon word addresses
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_DATA    = 3'd3;
  localparam logic [2:0] ADDR_OVERRUN = 3'd4;
  localparam logic [2:0] ADDR_GRANTS  = 3'd5;

  localparam logic [31:0] BLOCK_ID  = 32'h4C48_5331;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  // Control word bits
  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // Status word layout
  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_LEVEL_W   = 7;
  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_ID_LSB    = 24;

  // One FIFO entry: originating sensor index plus its combined_data word
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } entry_t;

  // Assemble the status register from FIFO state
  function automatic logic [31:0] status_word(input logic [STAT_LEVEL_W-1:0] level,
                                              input logic empty,
                                              input logic full,
                                              input logic [3:0] head_id);
    logic [31:0] s;
    s = '0;
    s[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
    s[STAT_EMPTY_BIT]                 = empty;
    s[STAT_FULL_BIT]                  = full;
    s[STAT_ID_LSB +: 4]               = head_id;
    return s;
  endfunction

endpackage

// File: rtl/lighthouse_sample_fifo.sv
// Single-clock sample FIFO holding tagged sensor entries.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
module lighthouse_sample_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 36
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push   = push && !full && !clear;
  assign do_pop    = pop && !empty && !clear;

  // Next pointer values; clear collapses both pointers to an empty FIFO
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lighthouse_sensor_arbiter.sv
// Latches decoder samples into per-sensor slots and round-robins them into a tagged FIFO read over Avalon-MM.
// Latency: valid in cycle N -> grant in N+1 -> entry visible at N+2; readdata is combinational.
// Backpressure: no grant while the FIFO is full; slots hold data, later valids overwrite and count as overruns.
module lighthouse_sensor_arbiter
  import lighthouse_arbiter_pkg::*;
#(
  parameter int NUM_SENSORS = 16,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SENSORS-1:0]     sensor_valid,
  input  logic [32*NUM_SENSORS-1:0]  sensor_data,
  input  logic [2:0]                 address,
  input  logic                       write,
  input  logic [31:0]                writedata,
  input  logic                       read,
  output logic [31:0]                readdata,
  output logic                       waitrequest,
  output logic                       irq
);

  localparam int IW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Round-robin pick over req, starting just after last; returns {found, index}
  function automatic logic [4:0] rr_pick(input logic [NUM_SENSORS-1:0] req, input logic [3:0] last);
    logic [4:0] res;
    int         idx;
    res = '0;
    for (int k = 1; k <= NUM_SENSORS; k++) begin
      idx = (int'(last) + k) % NUM_SENSORS;
      if (!res[4] && req[idx[IW-1:0]]) res = {1'b1, 4'(idx)};
    end
    return res;
  endfunction

  logic [NUM_SENSORS-1:0] mask_q, mask_d, mask_new;
  logic                   irq_en_q, irq_en_d;
  logic [NUM_SENSORS-1:0] pending_q, pending_d;
  logic [31:0]            slot_data_q [NUM_SENSORS];
  logic [31:0]            slot_data_d [NUM_SENSORS];
  logic [3:0]             last_grant_q, last_grant_d;
  logic [15:0]            overrun_q, overrun_d;
  logic [31:0]            grant_cnt_q, grant_cnt_d;

  logic                   ctrl_wr, mask_wr, clear, pop;
  logic [4:0]             pick;
  logic                   grant_vld;
  logic [3:0]             grant_id;
  logic [NUM_SENSORS-1:0] grant_onehot;
  logic [4:0]             ovr_inc;
  logic [16:0]            ovr_sum;

  entry_t                 push_entry, head_entry;
  logic [LW-1:0]          fifo_level;
  logic                   fifo_empty, fifo_full;
  logic [31:0]            mask_word;
  logic                   unused_wdata;

  assign ctrl_wr  = write && (address == ADDR_CTRL);
  assign mask_wr  = write && (address == ADDR_MASK);
  assign clear    = ctrl_wr && writedata[CTRL_CLEAR_BIT];
  assign pop      = read && (address == ADDR_DATA) && !fifo_empty;
  assign mask_new = mask_wr ? writedata[NUM_SENSORS-1:0] : mask_q;

  // A slot being masked off this cycle is no longer eligible for a grant
  assign pick         = rr_pick(pending_q & mask_new, last_grant_q);
  assign grant_vld    = pick[4] && !fifo_full && !clear;
  assign grant_id     = pick[3:0];
  assign grant_onehot = grant_vld ? (NUM_SENSORS'(1) << grant_id) : '0;

  assign push_entry.id   = grant_id;
  assign push_entry.data = slot_data_q[grant_id[IW-1:0]];

  assign waitrequest  = 1'b0;
  assign irq          = irq_en_q && !fifo_empty;
  assign unused_wdata = &{1'b0, writedata};

  lighthouse_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .push      (grant_vld),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Slot capture: grant retires a slot, a fresh valid re-arms it, mask-off and clear drop it
  always_comb begin
    pending_d   = pending_q;
    slot_data_d = slot_data_q;
    ovr_inc     = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (grant_onehot[i]) pending_d[i] = 1'b0;
      if (sensor_valid[i] && mask_q[i]) begin
        slot_data_d[i] = sensor_data[32*i +: 32];
        if (pending_q[i] && !grant_onehot[i]) ovr_inc = ovr_inc + 5'd1;
        pending_d[i] = 1'b1;
      end
      if (mask_wr && !writedata[i]) pending_d[i] = 1'b0;
    end
    if (clear) pending_d = '0;
  end

  // Control, mask, counters and round-robin pointer next state
  always_comb begin
    mask_d       = mask_new;
    irq_en_d     = ctrl_wr ? writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
    ovr_sum      = {1'b0, overrun_q} + {12'd0, ovr_inc};
    overrun_d    = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    grant_cnt_d  = grant_vld ? grant_cnt_q + 32'd1 : grant_cnt_q;
    last_grant_d = grant_vld ? grant_id : last_grant_q;
    if (clear) begin
      overrun_d    = '0;
      grant_cnt_d  = '0;
      last_grant_d = 4'(NUM_SENSORS - 1);
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q       <= '0;
      irq_en_q     <= 1'b0;
      pending_q    <= '0;
      last_grant_q <= 4'(NUM_SENSORS - 1);
      overrun_q    <= '0;
      grant_cnt_q  <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) slot_data_q[i] <= '0;
    end else begin
      mask_q       <= mask_d;
      irq_en_q     <= irq_en_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      overrun_q    <= overrun_d;
      grant_cnt_q  <= grant_cnt_d;
      slot_data_q  <= slot_data_d;
    end
  end

  // Zero-latency read mux
  always_comb begin
    mask_word = '0;
    mask_word[NUM_SENSORS-1:0] = mask_q;
    case (address)
      ADDR_CTRL:    readdata = BLOCK_ID;
      ADDR_MASK:    readdata = mask_word;
      ADDR_STATUS:  readdata = status_word(7'(fifo_level), fifo_empty, fifo_full,
                                           fifo_empty ? 4'd0 : head_entry.id);
      ADDR_DATA:    readdata = fifo_empty ? DEAD_BEEF : head_entry.data;
      ADDR_OVERRUN: readdata = {16'd0, overrun_q};
      ADDR_GRANTS:  readdata = grant_cnt_q;
      default:      readdata = DEAD_BEEF;
    endcase
  end

endmodule
